// File: rtl/frame_scanout.sv
// Framebuffer read-out engine: sweeps a 320x240 frame, issues one SRAM read per pixel
// and re-times the fixed-latency returns into a credit-limited valid/ready pixel stream.
module frame_scanout #(
    parameter int unsigned PIXEL_W    = 16,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               scan_start,
    output logic               scan_busy,
    output logic               scan_done,
    output logic               rd_en,
    output logic [8:0]         rd_x,
    output logic [7:0]         rd_y,
    input  logic [PIXEL_W-1:0] rd_data,
    output logic               px_valid,
    input  logic               px_ready,
    output logic [PIXEL_W-1:0] px_data,
    output logic               px_sof,
    output logic               px_eol
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [8:0]  X_LAST = 9'd319;
    localparam logic [7:0]  Y_LAST = 8'd239;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [8:0]      x_q;
    logic [7:0]      y_q;
    logic [CW-1:0]   credits;
    logic            done_q;
    logic            done_nxt;
    logic            pop;
    logic            push;

    logic [RD_LATENCY-1:0] tag_vld;
    logic [RD_LATENCY-1:0] tag_sof;
    logic [RD_LATENCY-1:0] tag_eol;

    logic [PIXEL_W+1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic [PIXEL_W+1:0] head;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= done_nxt;
        end
    end

    // A start arriving in the scan_done cycle is dropped so back-to-back frames are spaced.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        rd_en     = 1'b0;
        case (state)
            IDLE: begin
                if (scan_start && !done_q) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                if (credits < CW'(FIFO_DEPTH)) begin
                    rd_en = 1'b1;
                    if (x_q == X_LAST && y_q == Y_LAST) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (credits == CW'(1) && pop) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign scan_busy = (state != IDLE);
    assign scan_done = done_q;

    // ---------------------------------------------------------- coordinates
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (state == IDLE) begin
            x_q <= '0;
            y_q <= '0;
        end else if (rd_en) begin
            if (x_q == X_LAST) begin
                x_q <= '0;
                y_q <= (y_q == Y_LAST) ? '0 : y_q + 8'd1;
            end else begin
                x_q <= x_q + 9'd1;
            end
        end
    end

    assign rd_x = x_q;
    assign rd_y = y_q;

    // -------------------------------------------------------------- credits
    // Credits count reads in flight plus FIFO occupancy, so every return has a slot.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            credits <= '0;
        end else begin
            case ({rd_en, pop})
                2'b10:   credits <= credits + CW'(1);
                2'b01:   credits <= credits - CW'(1);
                default: credits <= credits;
            endcase
        end
    end

    // ----------------------------------------------------------- return tags
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tag_vld <= '0;
            tag_sof <= '0;
            tag_eol <= '0;
        end else begin
            tag_vld[0] <= rd_en;
            tag_sof[0] <= rd_en && (x_q == '0) && (y_q == '0);
            tag_eol[0] <= rd_en && (x_q == X_LAST);
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_sof[i] <= tag_sof[i-1];
                tag_eol[i] <= tag_eol[i-1];
            end
        end
    end

    assign push = tag_vld[RD_LATENCY-1];

    // ----------------------------------------------------------------- FIFO
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {tag_sof[RD_LATENCY-1], tag_eol[RD_LATENCY-1], rd_data};
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head     = mem[rd_ptr];
    assign px_valid = (count != '0);
    assign pop      = px_valid && px_ready;
    // Head is gated so the unreset storage never shows on the outputs.
    assign px_data  = px_valid ? head[PIXEL_W-1:0] : '0;
    assign px_sof   = px_valid && head[PIXEL_W+1];
    assign px_eol   = px_valid && head[PIXEL_W];

endmodule

// File: tb/tb_frame_scanout.sv
// Self-checking bench for frame_scanout: three instances (latency 2/1/3) against a
// frame-level reference model with random SRAM data and random downstream backpressure.
module tb_frame_scanout;

    localparam int NPIX = 76800;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst_b, start0, start_b, ready0;

    logic        busy_w     [3];
    logic        done_w     [3];
    logic        rd_en_w    [3];
    logic [8:0]  rd_x_w     [3];
    logic [7:0]  rd_y_w     [3];
    logic [15:0] rd_data_w  [3];
    logic        px_valid_w [3];
    logic [15:0] px_data_w  [3];
    logic        px_sof_w   [3];
    logic        px_eol_w   [3];

    frame_scanout #(.PIXEL_W(16), .RD_LATENCY(2), .FIFO_DEPTH(4)) u_dut0 (
        .clk(clk), .n_rst(rst0), .scan_start(start0), .scan_busy(busy_w[0]),
        .scan_done(done_w[0]), .rd_en(rd_en_w[0]), .rd_x(rd_x_w[0]), .rd_y(rd_y_w[0]),
        .rd_data(rd_data_w[0]), .px_valid(px_valid_w[0]), .px_ready(ready0),
        .px_data(px_data_w[0]), .px_sof(px_sof_w[0]), .px_eol(px_eol_w[0])
    );

    frame_scanout #(.PIXEL_W(16), .RD_LATENCY(1), .FIFO_DEPTH(3)) u_dut1 (
        .clk(clk), .n_rst(rst_b), .scan_start(start_b), .scan_busy(busy_w[1]),
        .scan_done(done_w[1]), .rd_en(rd_en_w[1]), .rd_x(rd_x_w[1]), .rd_y(rd_y_w[1]),
        .rd_data(rd_data_w[1]), .px_valid(px_valid_w[1]), .px_ready(1'b1),
        .px_data(px_data_w[1]), .px_sof(px_sof_w[1]), .px_eol(px_eol_w[1])
    );

    frame_scanout #(.PIXEL_W(16), .RD_LATENCY(3), .FIFO_DEPTH(5)) u_dut2 (
        .clk(clk), .n_rst(rst_b), .scan_start(start_b), .scan_busy(busy_w[2]),
        .scan_done(done_w[2]), .rd_en(rd_en_w[2]), .rd_x(rd_x_w[2]), .rd_y(rd_y_w[2]),
        .rd_data(rd_data_w[2]), .px_valid(px_valid_w[2]), .px_ready(1'b1),
        .px_data(px_data_w[2]), .px_sof(px_sof_w[2]), .px_eol(px_eol_w[2])
    );

    // SRAM model: the word chosen for a read appears exactly RD_LATENCY cycles later,
    // random junk otherwise.
    logic        pend_vld [3];
    logic [15:0] pend_d   [3];
    logic [15:0] pipe     [3][3];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            pipe[k][0] <= pend_vld[k] ? pend_d[k] : 16'($urandom);
            pipe[k][1] <= pipe[k][0];
            pipe[k][2] <= pipe[k][1];
        end
    end

    assign rd_data_w[0] = pipe[0][1];
    assign rd_data_w[1] = pipe[1][0];
    assign rd_data_w[2] = pipe[2][2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [15:0] exp_data [3][NPIX];
    int          rd_cnt    [3];
    int          pop_cnt   [3];
    int          first_cyc [3];
    int          done_cyc  [3];
    int          done_cnt  [3];
    int          max_out   [3];
    logic        prev_hold [3];
    logic [17:0] prev_px   [3];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int lat(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 3);
    endfunction

    function automatic logic [38:0] outs0();
        return {busy_w[0], done_w[0], rd_en_w[0], rd_x_w[0], rd_y_w[0], px_valid_w[0],
                px_data_w[0], px_sof_w[0], px_eol_w[0]};
    endfunction

    // Frame-level model: read n must target (n%320, n/320); pop n must deliver the word
    // supplied for read n, sof only at n==0, eol whenever n%320==319.
    task automatic mon(input int k, input logic rst, input logic re, input logic [8:0] rx,
                       input logic [7:0] ry, input logic pv, input logic pr,
                       input logic [15:0] pd, input logic sof, input logic eol,
                       input logic dn);
        logic [15:0] d;
        if (!rst) begin
            rd_cnt[k]    = 0;
            pop_cnt[k]   = 0;
            prev_hold[k] = 1'b0;
            pend_vld[k]  = 1'b0;
            return;
        end
        if (prev_hold[k]) check("hold_stable", {pv, sof, eol, pd}, {1'b1, prev_px[k]});
        if (pv && pr) begin
            if (pop_cnt[k] < rd_cnt[k] && pop_cnt[k] < NPIX)
                check("px", {sof, eol, pd}, {(pop_cnt[k] == 0), (pop_cnt[k] % 320 == 319),
                                             exp_data[k][pop_cnt[k]]});
            else
                check("px_without_read", 1, 0);
            pop_cnt[k]++;
        end
        pend_vld[k] = re;
        if (re) begin
            if (rd_cnt[k] < NPIX) begin
                check("rd_xy", {ry, rx}, {8'(rd_cnt[k] / 320), 9'(rd_cnt[k] % 320)});
                d = 16'($urandom);
                exp_data[k][rd_cnt[k]] = d;
                pend_d[k] = d;
            end else begin
                check("extra_rd", 1, 0);
            end
            rd_cnt[k]++;
        end
        prev_hold[k] = pv && !pr;
        prev_px[k]   = {sof, eol, pd};
        if (rd_cnt[k] - pop_cnt[k] > max_out[k]) max_out[k] = rd_cnt[k] - pop_cnt[k];
        if (pv && first_cyc[k] < 0) first_cyc[k] = cyc;
        if (dn) begin
            if (done_cnt[k] == 0) done_cyc[k] = cyc;
            done_cnt[k]++;
            check("done_after_last_px", pop_cnt[k], NPIX);
        end
    endtask

    task automatic advance();
        @(negedge clk);
        cyc++;
    endtask

    task automatic settle();
        #1;
        mon(0, rst0, rd_en_w[0], rd_x_w[0], rd_y_w[0], px_valid_w[0], ready0,
            px_data_w[0], px_sof_w[0], px_eol_w[0], done_w[0]);
        mon(1, rst_b, rd_en_w[1], rd_x_w[1], rd_y_w[1], px_valid_w[1], 1'b1,
            px_data_w[1], px_sof_w[1], px_eol_w[1], done_w[1]);
        mon(2, rst_b, rd_en_w[2], rd_x_w[2], rd_y_w[2], px_valid_w[2], 1'b1,
            px_data_w[2], px_sof_w[2], px_eol_w[2], done_w[2]);
    endtask

    initial begin
        rst0 = 1'b0; rst_b = 1'b0; start0 = 1'b0; start_b = 1'b0; ready0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rd_cnt[k] = 0; pop_cnt[k] = 0; first_cyc[k] = -1; done_cyc[k] = -1;
            done_cnt[k] = 0; max_out[k] = 0; prev_hold[k] = 1'b0; prev_px[k] = '0;
            pend_vld[k] = 1'b0; pend_d[k] = '0;
        end

        repeat (3) begin advance(); settle(); end
        check("reset_outputs", outs0(), 0);

        advance(); rst0 = 1'b1; rst_b = 1'b1; settle();
        repeat (5) begin
            advance(); settle();
            check("idle_quiet", {px_valid_w[0], busy_w[0], rd_en_w[0]}, 0);
        end

        // Frame A: full throughput on all three instances, plus ignored starts.
        advance(); cyc = 0; start0 = 1'b1; start_b = 1'b1; ready0 = 1'b1; settle();
        while (cyc < 76807) begin
            advance();
            start0  = (cyc == 300 || cyc == 76801 || cyc == 76804 || cyc == 76806);
            start_b = (cyc == 300 || cyc == 76803);
            settle();
            if (cyc == 1) check("busy_cycle1", {busy_w[0], rd_en_w[0]}, 2'b11);
            if (cyc == 76804) check("busy_fall_with_done", {busy_w[0], done_w[0]}, 2'b01);
            if (cyc == 76805) begin
                check("start_in_done_ignored", busy_w[0], 0);
                check("frameA_pixels_k0", pop_cnt[0], NPIX);
                rd_cnt[0]  = 0;
                pop_cnt[0] = 0;
            end
        end
        check("restart_accepted", {busy_w[0], rd_en_w[0]}, 2'b11);
        for (int k = 0; k < 3; k++) begin
            check("first_px_cycle", first_cyc[k], lat(k) + 2);
            check("done_cycle", done_cyc[k], NPIX + lat(k) + 2);
            check("done_once", done_cnt[k], 1);
        end
        check("frameA_pixels_k1", pop_cnt[1], NPIX);
        check("frameA_pixels_k2", pop_cnt[2], NPIX);
        check("k1_idle_after_ignored_start", busy_w[1], 0);

        // Frame B: random backpressure with a 20-cycle stall at pixel 100.
        for (int i = 0; i < 2000 && pop_cnt[0] < 100; i++) begin
            advance(); ready0 = 1'($urandom_range(0, 1)); settle();
        end
        check("reached_px100", pop_cnt[0] >= 100, 1);
        repeat (20) begin advance(); ready0 = 1'b0; settle(); end
        check("stall_rd_en", rd_en_w[0], 0);
        check("stall_credits_full", rd_cnt[0] - pop_cnt[0], 4);
        check("stall_px_valid", px_valid_w[0], 1);
        repeat (3000) begin advance(); ready0 = 1'($urandom_range(0, 1)); settle(); end
        check("frameB_progress", pop_cnt[0] > 1000, 1);

        // Asynchronous reset mid-frame, then a clean restart.
        advance(); rst0 = 1'b0; settle();
        check("midframe_reset_outputs", outs0(), 0);
        advance(); settle();
        advance(); rst0 = 1'b1; settle();
        repeat (20) begin
            advance(); ready0 = 1'($urandom_range(0, 1)); settle();
            check("post_reset_quiet", {px_valid_w[0], busy_w[0]}, 0);
        end
        advance(); start0 = 1'b1; settle();
        repeat (600) begin
            advance(); start0 = 1'b0; ready0 = 1'($urandom_range(0, 1)); settle();
        end
        check("frameC_progress", pop_cnt[0] > 100, 1);
        check("k0_done_total", done_cnt[0], 1);
        for (int k = 0; k < 3; k++) check("credit_max", max_out[k] <= lat(k) + 2, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
